// File: rtl/wave_gen_top.sv
// Waveform generator for a 10-bit R-2R DAC: a divided phase counter indexes
// sawtooth/triangle/sine/square generators, and the result is registered onto the board pins.
module wave_gen_top #(
   parameter int SAMPLE_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] selector,
   output logic       _9b,
   output logic       _6a,
   output logic       _4a,
   output logic       _2a,
   output logic       _0a,
   output logic       _5a,
   output logic       _3b,
   output logic       _49a,
   output logic       _45a,
   output logic       _48b
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   // First quarter of round(511.5 + 511.5*sin(2*pi*n/256)), n = 0..64
   localparam logic [9:0] Q_ROM [0:64] = '{
      10'd512,  10'd524,  10'd537,  10'd549,  10'd562,  10'd574,  10'd587,  10'd599,
      10'd611,  10'd624,  10'd636,  10'd648,  10'd660,  10'd672,  10'd684,  10'd696,
      10'd707,  10'd719,  10'd730,  10'd741,  10'd753,  10'd764,  10'd774,  10'd785,
      10'd796,  10'd806,  10'd816,  10'd826,  10'd836,  10'd846,  10'd855,  10'd864,
      10'd873,  10'd882,  10'd890,  10'd899,  10'd907,  10'd915,  10'd922,  10'd930,
      10'd937,  10'd944,  10'd950,  10'd957,  10'd963,  10'd968,  10'd974,  10'd979,
      10'd984,  10'd989,  10'd993,  10'd997,  10'd1001, 10'd1004, 10'd1008, 10'd1011,
      10'd1013, 10'd1015, 10'd1017, 10'd1019, 10'd1021, 10'd1022, 10'd1022, 10'd1023,
      10'd1023
   };

   logic [DIV_W-1:0] r_div;
   logic [7:0]       r_phase;
   logic [9:0]       r_dac;
   logic [6:0]       w_q_idx;
   logic [9:0]       w_q;
   logic [9:0]       w_sine;
   logic [9:0]       w_wave;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div   <= '0;
         r_phase <= '0;
         r_dac   <= '0;
      end else begin
         if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_phase <= r_phase + 8'd1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         r_dac <= w_wave;
      end
   end

   // Fold the phase onto the quarter-wave table
   always_comb begin
      w_q_idx = 7'd0;
      if (r_phase <= 8'd64)
         w_q_idx = r_phase[6:0];
      else if (r_phase < 8'd128)
         w_q_idx = 7'(8'd128 - r_phase);
      else if (r_phase <= 8'd192)
         w_q_idx = 7'(r_phase - 8'd128);
      else
         w_q_idx = 7'(9'd256 - {1'b0, r_phase});
   end

   assign w_q = Q_ROM[w_q_idx];

   // n=128 is the one rounding tie where 1023-q(0) would give 511 instead of 512
   always_comb begin
      w_sine = 10'd512;
      if (r_phase < 8'd128)
         w_sine = w_q;
      else if (r_phase != 8'd128)
         w_sine = 10'd1023 - w_q;
   end

   always_comb begin
      w_wave = 10'd512;
      case (selector)
         4'b0001: w_wave = {r_phase, 2'b00};
         4'b0010: w_wave = r_phase[7] ? {~r_phase[6:0], 3'b000} : {r_phase[6:0], 3'b000};
         4'b0100: w_wave = w_sine;
         4'b1000: w_wave = r_phase[7] ? 10'd0 : 10'd1023;
         default: w_wave = 10'd512;
      endcase
   end

   assign {_9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b} = r_dac;

endmodule

// File: tb/tb_wave_gen_top.sv
// Self-checking bench for wave_gen_top: reference waveforms are computed from the
// closed-form definitions (including $sin for the sine) and a cycle count since reset.
module tb_wave_gen_top;

   localparam int DIV = 4;
   localparam int NV  = 22;

   typedef struct {
      logic [3:0] sel;
      int         ph;
      int         exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] selector = 4'b0100;
   logic       _9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b;
   logic [9:0] dac;

   int nerr  = 0;
   int nchk  = 0;
   int edges = 0;
   int hist [0:1279];
   vec_t tbl [NV];

   wave_gen_top #(.SAMPLE_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .selector(selector),
      ._9b(_9b), ._6a(_6a), ._4a(_4a), ._2a(_2a), ._0a(_0a),
      ._5a(_5a), ._3b(_3b), ._49a(_49a), ._45a(_45a), ._48b(_48b)
   );

   assign dac = {_9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b};

   always #5 clk = ~clk;

   function automatic int wave(input logic [3:0] s, input int n);
      real v;
      int  iv;
      case (s)
         4'b0001: return n * 4;
         4'b0010: return (n < 128) ? n * 8 : (255 - n) * 8;
         4'b0100: begin
            v  = 511.5 + 511.5 * $sin(2.0 * 3.14159265358979 * n / 256.0);
            iv = $rtoi(v + 0.5);
            if (iv < 0) iv = 0;
            if (iv > 1023) iv = 1023;
            return iv;
         end
         4'b1000: return (n < 128) ? 1023 : 0;
         default: return 512;
      endcase
   endfunction

   function automatic int cur_phase();
      return (edges / DIV) % 256;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: drive selector, take the edge, compare against the model if asked
   task automatic cyc(input logic [3:0] s, input bit do_chk, input string nm);
      int ph;
      ph = cur_phase();
      selector = s;
      @(posedge clk);
      edges++;
      #1;
      if (do_chk) chk(nm, {22'd0, dac}, wave(s, ph));
   endtask

   task automatic goto_phase(input int p, input logic [3:0] s);
      int guard;
      guard = 0;
      while (cur_phase() != p && guard < 1100) begin
         cyc(s, 1'b0, "");
         guard++;
      end
      if (guard >= 1100) begin
         nchk++;
         nerr++;
         $display("FAIL goto_phase: phase %0d not reached, got %0d", p, cur_phase());
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pins", {22'd0, dac}, 32'd0);
      #3;
      rst   = 1'b0;
      edges = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int   prev, prev_ph, ph, cnt;
      logic [3:0] rsel;

      tbl = '{
         '{4'b0100,   0,  512}, '{4'b0001,   0,    0}, '{4'b0010,   0,    0}, '{4'b1000,   0, 1023},
         '{4'b0100,  16,  707}, '{4'b0100,  32,  873}, '{4'b0000,  50,  512},
         '{4'b0100,  64, 1023}, '{4'b0010,  64,  512}, '{4'b0110, 100,  512},
         '{4'b0010, 127, 1016}, '{4'b1000, 127, 1023},
         '{4'b0100, 128,  512}, '{4'b0010, 128, 1016}, '{4'b1000, 128,    0}, '{4'b0001, 128,  512},
         '{4'b0100, 192,    0}, '{4'b1111, 200,  512},
         '{4'b0001, 255, 1020}, '{4'b0010, 255,    0}, '{4'b1000, 255,    0},
         '{4'b0001,   0,    0}
      };

      // Reset and settle
      selector = 4'b0100;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold_pins", {22'd0, dac}, 32'd0);
      #3;
      rst   = 1'b0;
      edges = 0;
      cyc(4'b0100, 1'b1, "first_edge");
      chk("first_edge_512", {22'd0, dac}, 32'd512);
      repeat (3) cyc(4'b0100, 1'b1, "settle");
      cyc(4'b0100, 1'b1, "phase1");
      chk("phase1_after_4_edges", {22'd0, dac}, 32'd524);

      // Sine sweep: value, landmarks, monotonic quarters, period
      do_reset();
      prev = -1;
      prev_ph = -1;
      for (int e = 0; e < 1280; e++) begin
         ph = cur_phase();
         cyc(4'b0100, 1'b1, "sine_sweep");
         hist[e] = int'(dac);
         if (ph == 64)  chk("sine_peak", {22'd0, dac}, 32'd1023);
         if (ph == 128) chk("sine_mid",  {22'd0, dac}, 32'd512);
         if (ph == 192) chk("sine_min",  {22'd0, dac}, 32'd0);
         if (ph != prev_ph && prev >= 0) begin
            if ((ph >= 65 && ph <= 192))
               chk("sine_falling", {31'd0, hist[e] <= prev}, 32'd1);
            else
               chk("sine_rising", {31'd0, hist[e] >= prev}, 32'd1);
         end
         if (ph != prev_ph) begin
            prev    = hist[e];
            prev_ph = ph;
         end
         if (e >= 1024) chk("sine_period", hist[e], hist[e - 1024]);
      end

      // Table of single-sample points
      do_reset();
      for (int i = 0; i < NV; i++) begin
         goto_phase(tbl[i].ph, 4'b0001);
         cyc(tbl[i].sel, 1'b0, "");
         chk($sformatf("vec%0d_sel%b_ph%0d", i, tbl[i].sel, tbl[i].ph), {22'd0, dac}, tbl[i].exp);
      end

      // Pin mapping
      goto_phase(1, 4'b0001);
      cyc(4'b0001, 1'b0, "");
      chk("pins_saw4", {22'd0, dac}, 32'd4);
      chk("pin_49a_high", {31'd0, _49a}, 32'd1);
      goto_phase(128, 4'b0001);
      cyc(4'b0001, 1'b0, "");
      chk("pins_saw512", {22'd0, dac}, 32'd512);
      chk("pin_9b_high", {31'd0, _9b}, 32'd1);

      // Sawtooth to sine switch at phase 64
      goto_phase(64, 4'b0001);
      cyc(4'b0100, 1'b0, "");
      chk("saw_to_sine", {22'd0, dac}, 32'd1023);
      repeat (10) cyc(4'b0100, 1'b1, "after_switch");

      // Asynchronous reset mid-period
      goto_phase(100, 4'b0100);
      cyc(4'b0100, 1'b1, "pre_async_rst");
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_no_clk", {22'd0, dac}, 32'd0);
      repeat (2) @(posedge clk);
      #4;
      rst   = 1'b0;
      edges = 0;
      cyc(4'b0100, 1'b1, "restart");
      chk("restart_512", {22'd0, dac}, 32'd512);
      repeat (11) cyc(4'b0100, 1'b1, "restart");

      // Randomized selector changes against the model
      rsel = 4'b0001;
      cnt  = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(15) == 0) begin
            if ($urandom_range(3) == 0) rsel = 4'($urandom_range(15));
            else                        rsel = 4'(1 << $urandom_range(3));
            cnt++;
         end
         cyc(rsel, 1'b1, $sformatf("rand_sel%b", rsel));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/wave_gen_top.md
Name: wave_gen_top

Overview:
- FPGA-side waveform generator driving a 10-bit parallel R-2R DAC through ten individually named board pins.
- A free-running phase counter steps through a 256-sample period at a fixed sample rate.
- A 4-bit one-hot `selector` chooses sawtooth, triangle, sine or square.
- This is the top-level of the FPGA client; the pins map directly to board header pads.

Parameters:
- SAMPLE_DIV, default 4: clock cycles per sample step (one waveform period = 256*SAMPLE_DIV cycles); legal values are ≥1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- selector  input  4  one-hot waveform select.
- _9b  output  1  DAC bit 9 (MSB).
- _6a  output  1  DAC bit 8.
- _4a  output  1  DAC bit 7.
- _2a  output  1  DAC bit 6.
- _0a  output  1  DAC bit 5.
- _5a  output  1  DAC bit 4.
- _3b  output  1  DAC bit 3.
- _49a  output  1  DAC bit 2.
- _45a  output  1  DAC bit 1.
- _48b  output  1  DAC bit 0 (LSB).

Behaviour:
- Internal state:
  - div counter, width ceil(log2(SAMPLE_DIV)) (min 1).
  - phase, 8 bits.
  - dac register, 10 bits; it drives the ten pins in the order above.
- Reset (asynchronous assert, any time including mid-period):
  - div=0, phase=0, dac=0, so all pins are 0.
  - Reset is released synchronously to clk.
- Divider:
  - Each clk edge out of reset: if div==SAMPLE_DIV-1, then div←0 and phase←phase+1 (mod 256, wraps 255→0 with no gap).
  - Otherwise div←div+1.
- Output:
  - Every clk edge out of reset, dac←wave(selector, phase), using the phase value before that edge's update.
  - Latency is exactly 1 cycle from phase to pins. There is no glitching: pins come only from the register.
- wave(selector, n), n in 0..255:
  - 4'b0001 sawtooth: n*4 (0..1020).
  - 4'b0010 triangle: n<128 ? n*8 : (255-n)*8 (peak 1016 at n=127 and n=128).
  - 4'b0100 sine: round(511.5 + 511.5*sin(2*pi*n/256)), clamped to 0..1023.
    - Required points: n=0 → 512, n=64 → 1023, n=128 → 512, n=192 → 0.
    - Implemented as a 65-entry quarter-wave ROM (n=0..64) with mirror/negate symmetry:
      - first quarter, n 0..64: q(n).
      - second quarter, n 65..127: q(128-n).
      - third quarter, n 128..191: 1023-q(n-128).
      - fourth quarter, n 192..255: 1023-q(256-n).
    - q(0) is defined as 512; the symmetry must reproduce the required points exactly.
  - 4'b1000 square: n<128 ? 1023 : 0.
  - Any other selector value (zero or multi-hot): 512 (midscale hold).
- Selector changes:
  - Take effect on the next clk edge.
  - Phase and divider are not disturbed, so the waveform continues from the current phase.
- Selector is treated as synchronous to clk; no internal synchronizer.

Test Plan:
- Reset and settle: hold rst=1 with selector=4'b0100 → all ten pins 0. Release rst → after first clk edge dac=512; phase becomes 1 after 4 edges (SAMPLE_DIV=4).
- Sine sweep, selector=4'b0100, 1280 cycles:
  - dac=1023 while phase=64.
  - dac=512 at phase=128.
  - dac=0 at phase=192.
  - Period = 1024 cycles.
  - Successive samples are monotonic within each quarter.
- Other waves:
  - Sawtooth: phase=255 → 1020, then 0 after wrap.
  - Triangle: phase=127 and phase=128 → 1016; phase=0 → 0.
  - Square: 1023 for phase 0..127, 0 for 128..255.
- Selector edge cases:
  - selector=4'b0000 or 4'b0110 → dac holds 512.
  - Switching sawtooth→sine at phase=64 gives 1023 on the next edge; phase keeps counting.
- Mid-operation reset: assert rst asynchronously between clk edges at phase≈100 → pins drop to 0 immediately without waiting for clk; after release the sequence restarts from phase 0.
- Bit mapping: force phase where sawtooth = 4 (phase=1) → only _49a=1; phase=128 → only _9b=1.
